// File: rtl/line_rasterizer_if.sv
// Start/Done handshake and pixel stream between the triangle drawer,
// the line rasterizer and the frame-buffer writer.
interface line_rasterizer_if #(
    parameter int W = 10
);
    logic         start;
    logic [W-1:0] x0;
    logic [W-1:0] y0;
    logic [W-1:0] x1;
    logic [W-1:0] y1;
    logic         pixel_ready;
    logic [W-1:0] draw_x;
    logic [W-1:0] draw_y;
    logic         pixel_valid;
    logic         done;

    modport master (
        output start, x0, y0, x1, y1, pixel_ready,
        input  draw_x, draw_y, pixel_valid, done
    );

    modport slave (
        input  start, x0, y0, x1, y1, pixel_ready,
        output draw_x, draw_y, pixel_valid, done
    );
endinterface

// File: rtl/line_rasterizer.sv
// Integer Bresenham line rasterizer: latches two endpoints on a 4-phase
// Start/Done handshake and emits one pixel per accepted transfer.
module line_rasterizer #(
    parameter int W = 10
) (
    input logic               clk,
    input logic               rst,
    line_rasterizer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

    localparam int EW = W + 2;
    localparam logic signed [EW-1:0] ZERO = '0;

    state_t               state;
    logic [W-1:0]         end_x;
    logic [W-1:0]         end_y;
    logic signed [EW-1:0] dx;
    logic signed [EW-1:0] dy;
    logic signed [EW-1:0] err;
    logic                 sx_neg;
    logic                 sy_neg;

    logic [W-1:0]         abs_x;
    logic [W-1:0]         abs_y;
    logic signed [EW-1:0] dx_init;
    logic signed [EW-1:0] dy_init;
    logic signed [EW:0]   e2;
    logic signed [EW:0]   dx_ext;
    logic signed [EW:0]   dy_ext;
    logic                 step_x;
    logic                 step_y;
    logic                 at_end;
    logic signed [EW-1:0] err_next;

    // dy is kept negative so both step tests compare against the same doubled error.
    always_comb begin
        abs_x    = (bus.x1 >= bus.x0) ? (bus.x1 - bus.x0) : (bus.x0 - bus.x1);
        abs_y    = (bus.y1 >= bus.y0) ? (bus.y1 - bus.y0) : (bus.y0 - bus.y1);
        dx_init  = $signed({2'b00, abs_x});
        dy_init  = -$signed({2'b00, abs_y});
        e2       = {err, 1'b0};
        dx_ext   = {dx[EW-1], dx};
        dy_ext   = {dy[EW-1], dy};
        step_x   = (e2 >= dy_ext);
        step_y   = (e2 <= dx_ext);
        err_next = err + (step_x ? dy : ZERO) + (step_y ? dx : ZERO);
        at_end   = (bus.draw_x == end_x) && (bus.draw_y == end_y);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            end_x           <= '0;
            end_y           <= '0;
            dx              <= '0;
            dy              <= '0;
            err             <= '0;
            sx_neg          <= 1'b0;
            sy_neg          <= 1'b0;
            bus.draw_x      <= '0;
            bus.draw_y      <= '0;
            bus.pixel_valid <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    end_x           <= bus.x1;
                    end_y           <= bus.y1;
                    dx              <= dx_init;
                    dy              <= dy_init;
                    err             <= dx_init + dy_init;
                    sx_neg          <= (bus.x1 < bus.x0);
                    sy_neg          <= (bus.y1 < bus.y0);
                    bus.draw_x      <= bus.x0;
                    bus.draw_y      <= bus.y0;
                    bus.pixel_valid <= 1'b1;
                    state           <= DRAW;
                end
                DRAW: begin
                    if (bus.pixel_ready) begin
                        if (at_end) begin
                            bus.pixel_valid <= 1'b0;
                            bus.done        <= 1'b1;
                            state           <= DONE;
                        end else begin
                            err <= err_next;
                            if (step_x) begin
                                bus.draw_x <= sx_neg ? (bus.draw_x - W'(1)) : (bus.draw_x + W'(1));
                            end
                            if (step_y) begin
                                bus.draw_y <= sy_neg ? (bus.draw_y - W'(1)) : (bus.draw_y + W'(1));
                            end
                        end
                    end
                end
                DONE: begin
                    // No re-trigger from here: Start must be seen low before the next line.
                    if (!bus.start) begin
                        bus.done <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
